// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI host sequencer: FSM states,
// key-size codes, size-byte values and frame geometry.
package aes_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_ISSUE    = 4'd2,
    ST_WAIT_TX  = 4'd3,
    ST_GAP      = 4'd4,
    ST_WAIT_RES = 4'd5,
    ST_RD_ISSUE = 4'd6,
    ST_RD_WAIT  = 4'd7,
    ST_RD_GAP   = 4'd8,
    ST_DONE     = 4'd9,
    ST_ERR      = 4'd10
  } seq_state_e;

  localparam logic [1:0] KS_128     = 2'b00;
  localparam logic [1:0] KS_192     = 2'b01;
  localparam logic [1:0] KS_256     = 2'b10;
  localparam logic [1:0] KS_ILLEGAL = 2'b11;

  localparam logic [7:0] SZ_128 = 8'h10;
  localparam logic [7:0] SZ_192 = 8'h18;
  localparam logic [7:0] SZ_256 = 8'h20;

  localparam int PT_BYTES      = 16;
  localparam int MAX_KEY_BYTES = 32;
  localparam int IDX_W         = 6;
  localparam int RD_W          = 5;

  // The size byte doubles as the key length in bytes.
  function automatic logic [7:0] size_byte(input logic [1:0] ks);
    case (ks)
      KS_192:  size_byte = SZ_192;
      KS_256:  size_byte = SZ_256;
      default: size_byte = SZ_128;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] frame_len(input logic [1:0] ks);
    case (ks)
      KS_192:  frame_len = IDX_W'(PT_BYTES + 1 + 24);
      KS_256:  frame_len = IDX_W'(PT_BYTES + 1 + MAX_KEY_BYTES);
      default: frame_len = IDX_W'(PT_BYTES + 1 + 16);
    endcase
  endfunction

endpackage

// File: rtl/aes_frame_mux.sv
// Selects frame byte i_idx: 16 plaintext bytes, one size byte, then key
// bytes, each field most-significant byte first.
module aes_frame_mux
  import aes_spi_pkg::*;
(
  input  logic [127:0]     i_plaintext,
  input  logic [255:0]     i_key,
  input  logic [1:0]       i_key_size,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_byte
);

  logic [3:0] w_pt_sel;
  logic [4:0] w_key_sel;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    w_pt_sel  = i_idx[3:0];
    w_key_sel = 5'(i_idx - IDX_W'(PT_BYTES + 1));
    o_byte    = 8'h00;
    if (i_idx < IDX_W'(PT_BYTES)) begin
      o_byte = i_plaintext[{~w_pt_sel, 3'b000} +: 8];
    end else if (i_idx == IDX_W'(PT_BYTES)) begin
      o_byte = size_byte(i_key_size);
    end else begin
      o_byte = i_key[{~w_key_sel, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/aes_spi_host_sequencer.sv
// Drives one AES encryption transaction through the SPI master and collects
// the 16-byte ciphertext. Optional WAIT_RES timeout: AES_SEQ_TIMEOUT_EN.
module aes_spi_host_sequencer
  import aes_spi_pkg::*;
#(
  parameter int GAP_CYCLES = 4
`ifdef AES_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [127:0] plaintext,
  input  logic [255:0] key,
  input  logic [1:0]   key_size,
  output logic         master_start,
  output logic [7:0]   master_data_in,
  input  logic         master_busy,
  input  logic         master_done,
  input  logic [7:0]   master_data_out,
  input  logic         enc_sending,
  output logic [127:0] result,
  output logic         result_valid,
  output logic         error
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_e       r_state, w_next;
  logic [127:0]     r_pt;
  logic [255:0]     r_key;
  logic [1:0]       r_ks;
  logic [IDX_W-1:0] r_idx;
  logic [RD_W-1:0]  r_rd_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_data_in;
  logic [127:0]     r_shift;
  logic [127:0]     r_result;
  logic             r_result_valid;
  logic [7:0]       w_frame_byte;
  logic             w_accept;
  logic             w_gap_done;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_gap_done = (r_gap == GAP_W'(GAP_CYCLES - 1));

  aes_frame_mux u_frame_mux (
    .i_plaintext (r_pt),
    .i_key       (r_key),
    .i_key_size  (r_ks),
    .i_idx       (r_idx),
    .o_byte      (w_frame_byte)
  );

`ifdef AES_SEQ_TIMEOUT_EN
  logic [12:0] r_timeout;
  logic        w_timeout;

  assign w_timeout = (r_timeout == 13'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_timeout <= '0;
    else if (r_state == ST_WAIT_RES) r_timeout <= r_timeout + 13'd1;
    else                            r_timeout <= '0;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (cmd_valid) w_next = (key_size == KS_ILLEGAL) ? ST_ERR : ST_LOAD;
      ST_LOAD:     w_next = ST_ISSUE;
      ST_ISSUE:    if (!master_busy) w_next = ST_WAIT_TX;
      ST_WAIT_TX:  if (master_done) w_next = ST_GAP;
      ST_GAP:      if (w_gap_done) w_next = (r_idx == frame_len(r_ks)) ? ST_WAIT_RES : ST_LOAD;
      ST_WAIT_RES: begin
        if (enc_sending) w_next = ST_RD_ISSUE;
`ifdef AES_SEQ_TIMEOUT_EN
        else if (w_timeout) w_next = ST_ERR;
`endif
      end
      ST_RD_ISSUE: if (!master_busy) w_next = ST_RD_WAIT;
      ST_RD_WAIT:  if (master_done) w_next = ST_RD_GAP;
      ST_RD_GAP:   if (w_gap_done) w_next = (r_rd_cnt == RD_W'(PT_BYTES)) ? ST_DONE : ST_RD_ISSUE;
      ST_DONE:     w_next = ST_IDLE;
      ST_ERR:      w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pt           <= '0;
      r_key          <= '0;
      r_ks           <= '0;
      r_idx          <= '0;
      r_rd_cnt       <= '0;
      r_gap          <= '0;
      r_data_in      <= '0;
      r_shift        <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_pt     <= plaintext;
        r_key    <= key;
        r_ks     <= key_size;
        r_idx    <= '0;
        r_rd_cnt <= '0;
      end
      if (r_state == ST_LOAD)     r_data_in <= w_frame_byte;
      if (r_state == ST_WAIT_RES) r_data_in <= 8'h00;
      if (r_state == ST_WAIT_TX && master_done) r_idx <= r_idx + 1'b1;
      if (r_state == ST_RD_WAIT && master_done) begin
        r_shift  <= {r_shift[119:0], master_data_out};
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      // Gap counter holds at GAP_CYCLES rather than wrapping.
      if (r_state == ST_GAP || r_state == ST_RD_GAP) begin
        if (r_gap != GAP_W'(GAP_CYCLES)) r_gap <= r_gap + 1'b1;
      end else begin
        r_gap <= '0;
      end
      if (r_state == ST_DONE) r_result <= r_shift;
      r_result_valid <= (r_state == ST_DONE);
    end
  end

  assign cmd_ready      = (r_state == ST_IDLE);
  assign master_start   = ((r_state == ST_ISSUE) || (r_state == ST_RD_ISSUE)) && !master_busy;
  assign master_data_in = r_data_in;
  assign result         = r_result;
  assign result_valid   = r_result_valid;
  assign error          = (r_state == ST_ERR);

endmodule
